// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
//
// Control FSM for a multi-cycle MIPS-style datapath. Every instruction is
// walked through FETCH -> DECODE -> (EXEC -> [MEM] -> [WB] | BRJ) and the
// datapath controls are decoded from the current state plus the opcode/func
// captured when the instruction register is written. Memory waits in FETCH
// and MEM are bounded by MEM_TIMEOUT; an undefined opcode or an exhausted
// wait parks the FSM in FAULT until reset.
//
// Parameters
//   ALUOP_W      width of ALUOp (>= 4); the 4-bit ALU codes are zero-extended
//   MEM_TIMEOUT  memory wait cycles allowed before a timeout fault (1..255)
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   Reset_L      synchronous active-low reset
//   Opcode       instruction[31:26]
//   FuncCode     instruction[5:0]
//   Zero         ALU zero flag (consumed by the datapath through PCWriteCond)
//   MemReady     memory finishes the current access this cycle
//   PCWrite .. SignExtend   single-bit datapath controls
//   ALUSrc2      00 rt, 01 constant 4, 10 extended immediate, 11 shamt
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp        ALU operation
//   IllegalOp    sticky undefined-opcode fault flag
//   Timeout      sticky memory-timeout fault flag
//   State        current FSM state (debug)
// -----------------------------------------------------------------------------
module multi_cycle_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         FuncCode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc1,
    output logic               SignExtend,
    output logic [1:0]         ALUSrc2,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IllegalOp,
    output logic               Timeout,
    output logic [3:0]         State
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_WB     = 4'd4,
        ST_BRJ    = 4'd5,
        ST_FAULT  = 4'd15
    } state_t;

    // 4-bit ALU encoding
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // The wait that would be the MEM_TIMEOUT-th consecutive one is the last
    // allowed; the counter holds the number of waits already spent.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] opcode_q;
    logic [5:0] func_q;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       illegal_q;
    logic       timeout_q;
    logic       go_illegal;
    logic       go_timeout;

    // Raw write strobes before reset gating
    logic pc_write;
    logic pc_write_cond;
    logic ir_write;
    logic mem_write;
    logic reg_write;

    logic [3:0] alu_op4;

    // Instruction class of the latched opcode
    logic       is_rtype;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_j;
    logic       is_shift;
    logic       is_imm;
    logic       imm_sign;
    logic [3:0] imm_aluop;

    // Zero is routed to the datapath's branch logic, not used here.
    logic unused_zero;
    assign unused_zero = Zero;

    assign is_rtype = (opcode_q == OP_RTYPE);
    assign is_lw    = (opcode_q == OP_LW);
    assign is_sw    = (opcode_q == OP_SW);
    assign is_beq   = (opcode_q == OP_BEQ);
    assign is_j     = (opcode_q == OP_J);
    // SLL 000000, SRL 000010, SRA 000011 take the shift amount as operand
    assign is_shift = is_rtype &&
                      (func_q == 6'b000000 || func_q == 6'b000010 || func_q == 6'b000011);

    always_comb begin
        is_imm    = 1'b1;
        imm_sign  = 1'b0;
        imm_aluop = ALU_AND;
        case (opcode_q)
            OP_ADDI:  begin imm_aluop = ALU_ADD;  imm_sign = 1'b1; end
            OP_ADDIU: imm_aluop = ALU_ADDU;
            OP_SLTI:  begin imm_aluop = ALU_SLT;  imm_sign = 1'b1; end
            OP_SLTIU: imm_aluop = ALU_SLTU;
            OP_ANDI:  imm_aluop = ALU_AND;
            OP_ORI:   imm_aluop = ALU_OR;
            OP_XORI:  imm_aluop = ALU_XOR;
            OP_LUI:   imm_aluop = ALU_LUI;
            default:  is_imm = 1'b0;
        endcase
    end

    // State register and instruction latch
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state     <= ST_FETCH;
            wait_cnt  <= 8'd0;
            opcode_q  <= 6'd0;
            func_q    <= 6'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (ir_write) begin
                opcode_q <= Opcode;
                func_q   <= FuncCode;
            end
            if (go_illegal) illegal_q <= 1'b1;
            if (go_timeout) timeout_q <= 1'b1;
        end
    end

    // Next state and control decode
    always_comb begin
        state_next    = state;
        wait_next     = 8'd0;   // any state change clears the wait counter
        go_illegal    = 1'b0;
        go_timeout    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        ALUSrc1       = 1'b0;
        SignExtend    = 1'b0;
        ALUSrc2       = 2'b00;
        PCSource      = 2'b00;
        alu_op4       = ALU_AND;

        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrc2 = 2'b01;
                alu_op4 = ALU_ADD;
                // A ready on the last allowed wait still completes.
                if (MemReady) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    go_timeout = 1'b1;
                    state_next = ST_FAULT;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end

            ST_DECODE: begin
                ALUSrc2    = 2'b10;
                SignExtend = 1'b1;
                alu_op4    = ALU_ADD;
                if (is_beq || is_j) begin
                    state_next = ST_BRJ;
                end else if (is_rtype || is_lw || is_sw || is_imm) begin
                    state_next = ST_EXEC;
                end else begin
                    go_illegal = 1'b1;
                    state_next = ST_FAULT;
                end
            end

            ST_EXEC: begin
                if (is_rtype) begin
                    alu_op4 = ALU_FUNC;
                    if (is_shift) begin
                        ALUSrc1 = 1'b1;
                        ALUSrc2 = 2'b11;
                    end
                end else if (is_lw || is_sw) begin
                    alu_op4    = ALU_ADD;
                    ALUSrc2    = 2'b10;
                    SignExtend = 1'b1;
                end else begin
                    alu_op4    = imm_aluop;
                    ALUSrc2    = 2'b10;
                    SignExtend = imm_sign;
                end
                state_next = (is_lw || is_sw) ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                IorD      = 1'b1;
                MemRead   = is_lw;
                mem_write = is_sw;
                if (MemReady) begin
                    state_next = is_lw ? ST_WB : ST_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    go_timeout = 1'b1;
                    state_next = ST_FAULT;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                RegDst     = is_rtype;
                MemToReg   = is_lw;
                state_next = ST_FETCH;
            end

            ST_BRJ: begin
                if (is_beq) begin
                    alu_op4       = ALU_SUB;
                    pc_write_cond = 1'b1;
                    PCSource      = 2'b01;
                end else begin
                    pc_write = 1'b1;
                    PCSource = 2'b10;
                end
                state_next = ST_FETCH;
            end

            ST_FAULT: begin
                state_next = ST_FAULT;
            end

            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Write strobes are forced low while reset is asserted, so a reset that
    // lands mid-access cannot commit a write on the reset cycle itself.
    assign PCWrite     = pc_write      & Reset_L;
    assign PCWriteCond = pc_write_cond & Reset_L;
    assign IRWrite     = ir_write      & Reset_L;
    assign MemWrite    = mem_write     & Reset_L;
    assign RegWrite    = reg_write     & Reset_L;

    assign ALUOp     = ALUOP_W'(alu_op4);
    assign IllegalOp = illegal_q;
    assign Timeout   = timeout_q;
    assign State     = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control
//
// Two instances: dut_a with the default MEM_TIMEOUT (15) and dut_b with
// MEM_TIMEOUT=3. Only one is exercised at a time (selected by cur); the other
// is held in reset. The instruction-level model turns one instruction (opcode,
// func, fetch waits, mem waits, optional mid-MEM reset, fault hold) into the
// per-cycle list of expected outputs pushed on exp_q; a single negedge process
// pops and compares. Output vector layout:
//   [24:21] State [20] PCWrite [19] PCWriteCond [18] IRWrite [17] IorD
//   [16] MemRead [15] MemWrite [14] MemToReg [13] RegDst [12] RegWrite
//   [11] ALUSrc1 [10] SignExtend [9:8] ALUSrc2 [7:6] PCSource [5:2] ALUOp
//   [1] IllegalOp [0] Timeout
// -----------------------------------------------------------------------------
module tb_multi_cycle_control;

    localparam int TO_A = 15;
    localparam int TO_B = 3;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2,
                           S_MEM = 4'd3, S_WB = 4'd4, S_BRJ = 4'd5, S_FAULT = 4'd15;

    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                           A_SUB = 4'b0110, A_SLT = 4'b0111, A_ADDU = 4'b1000,
                           A_XOR = 4'b1010, A_SLTU = 4'b1011, A_LUI = 4'b1110,
                           A_FUNC = 4'b1111;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                           OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_XORI = 6'b001110, OP_LUI = 6'b001111,
                           OP_LW = 6'b100011, OP_SW = 6'b101011;

    localparam logic [5:0] LEGAL [13] = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU,
                                          OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
                                          OP_XORI, OP_LUI, OP_LW, OP_SW};

    // single-bit control flags, packed as vector bits [20:10]
    localparam logic [10:0] F_PCW = 11'h400, F_PCWC = 11'h200, F_IRW = 11'h100,
                            F_IORD = 11'h080, F_MR = 11'h040, F_MW = 11'h020,
                            F_M2R = 11'h010, F_RD = 11'h008, F_RW = 11'h004,
                            F_S1 = 11'h002, F_SE = 11'h001;
    localparam logic [10:0] STROBE_FL = F_PCW | F_PCWC | F_IRW | F_MW | F_RW;
    localparam logic [24:0] STROBE_MASK = {4'b0, STROBE_FL, 10'b0};
    localparam logic [24:0] FULL_MASK = {25{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic       rst_a, rst_b, rdy_a, rdy_b, zero_a, zero_b;
    logic [5:0] op_a, op_b, fn_a, fn_b;
    logic       pcw_a, pcwc_a, irw_a, iord_a, mr_a, mw_a, m2r_a, rd_a, rw_a, s1_a, se_a, ill_a, to_a;
    logic       pcw_b, pcwc_b, irw_b, iord_b, mr_b, mw_b, m2r_b, rd_b, rw_b, s1_b, se_b, ill_b, to_b;
    logic [1:0] s2_a, pcs_a, s2_b, pcs_b;
    logic [3:0] aop_a, st_a, aop_b, st_b;
    logic [24:0] vec_a, vec_b;

    multi_cycle_control dut_a (
        .CLK(clk), .Reset_L(rst_a), .Opcode(op_a), .FuncCode(fn_a), .Zero(zero_a),
        .MemReady(rdy_a), .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IRWrite(irw_a),
        .IorD(iord_a), .MemRead(mr_a), .MemWrite(mw_a), .MemToReg(m2r_a),
        .RegDst(rd_a), .RegWrite(rw_a), .ALUSrc1(s1_a), .SignExtend(se_a),
        .ALUSrc2(s2_a), .PCSource(pcs_a), .ALUOp(aop_a), .IllegalOp(ill_a),
        .Timeout(to_a), .State(st_a)
    );

    multi_cycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(TO_B)) dut_b (
        .CLK(clk), .Reset_L(rst_b), .Opcode(op_b), .FuncCode(fn_b), .Zero(zero_b),
        .MemReady(rdy_b), .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IRWrite(irw_b),
        .IorD(iord_b), .MemRead(mr_b), .MemWrite(mw_b), .MemToReg(m2r_b),
        .RegDst(rd_b), .RegWrite(rw_b), .ALUSrc1(s1_b), .SignExtend(se_b),
        .ALUSrc2(s2_b), .PCSource(pcs_b), .ALUOp(aop_b), .IllegalOp(ill_b),
        .Timeout(to_b), .State(st_b)
    );

    assign vec_a = {st_a, pcw_a, pcwc_a, irw_a, iord_a, mr_a, mw_a, m2r_a, rd_a, rw_a,
                    s1_a, se_a, s2_a, pcs_a, aop_a, ill_a, to_a};
    assign vec_b = {st_b, pcw_b, pcwc_b, irw_b, iord_b, mr_b, mw_b, m2r_b, rd_b, rw_b,
                    s1_b, se_b, s2_b, pcs_b, aop_b, ill_b, to_b};

    // ---------------- scoreboard ----------------
    int          total;
    int          bad;
    int          cur;        // 0 -> dut_a, 1 -> dut_b
    int          zero_mode;  // <0 random Zero, else fixed value
    logic [49:0] exp_q[$];   // {mask, value}
    logic [24:0] obs_q[$];   // observed vectors, for literal checks

    always @(negedge clk) begin
        logic [24:0] act;
        logic [49:0] e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = (cur == 0) ? vec_a : vec_b;
            obs_q.push_back(act);
            total++;
            if (((act ^ e[24:0]) & e[49:25]) != 25'd0) begin
                bad++;
                $display("FAIL cycle_check dut=%0d t=%0t got=%h want=%h mask=%h",
                         cur, $time, act, e[24:0], e[49:25]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [24:0] mk(input logic [3:0] st, input logic [10:0] fl,
                                       input logic [1:0] s2, input logic [1:0] pcs,
                                       input logic [3:0] aop, input logic [1:0] flt);
        return {st, fl, s2, pcs, aop, flt};
    endfunction

    function automatic logic [49:0] full(input logic [24:0] v);
        return {FULL_MASK, v};
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        for (int i = 0; i < 13; i++) if (LEGAL[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // I-type ALU table: {sign-extend, aluop}
    function automatic logic [4:0] imm_row(input logic [5:0] op);
        case (op)
            OP_ADDI:  return {1'b1, A_ADD};
            OP_ADDIU: return {1'b0, A_ADDU};
            OP_SLTI:  return {1'b1, A_SLT};
            OP_SLTIU: return {1'b0, A_SLTU};
            OP_ANDI:  return {1'b0, A_AND};
            OP_ORI:   return {1'b0, A_OR};
            OP_XORI:  return {1'b0, A_XOR};
            default:  return {1'b0, A_LUI};
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rl, input logic r, input logic [5:0] o,
                        input logic [5:0] f, input logic [49:0] e);
        logic z;
        z = (zero_mode < 0) ? rnd1() : zero_mode[0];
        if (cur == 0) begin
            rst_a = rl; rdy_a = r; op_a = o; fn_a = f; zero_a = z;
        end else begin
            rst_b = rl; rdy_b = r; op_b = o; fn_b = f; zero_b = z;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // FAULT for 'hold' cycles, then one reset cycle (still FAULT on that cycle)
    task automatic fault_seq(input logic [1:0] flt, input int hold);
        for (int i = 0; i < hold; i++)
            step(1'b1, rnd1(), rnd6(), rnd6(), full(mk(S_FAULT, 11'h0, 2'b00, 2'b00, A_AND, flt)));
        step(1'b0, rnd1(), rnd6(), rnd6(), full(mk(S_FAULT, 11'h0, 2'b00, 2'b00, A_AND, flt)));
    endtask

    // One instruction end to end. fw/mwait: ready-low cycles in FETCH/MEM.
    // abort_at >= 0: reset is asserted on that MEM cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mwait, input int abort_at, input int hold);
        int          t;
        logic        r;
        logic [10:0] fl;
        logic [4:0]  row;
        logic        is_r, is_lw, is_sw, shift;
        t     = (cur == 0) ? TO_A : TO_B;
        is_r  = (op == OP_R);
        is_lw = (op == OP_LW);
        is_sw = (op == OP_SW);
        shift = is_r && (fn == 6'd0 || fn == 6'd2 || fn == 6'd3);

        // FETCH: junk on the instruction bus until the ready cycle
        for (int i = 0; i <= t; i++) begin
            r  = (i >= fw);
            fl = F_MR | (r ? (F_PCW | F_IRW) : 11'h0);
            step(1'b1, r, r ? op : rnd6(), r ? fn : rnd6(),
                 full(mk(S_FETCH, fl, 2'b01, 2'b00, A_ADD, 2'b00)));
            if (r) break;
            if (i + 1 == t) begin
                fault_seq(2'b01, hold);
                return;
            end
        end

        // DECODE: bus now carries junk, latched values must be used
        step(1'b1, rnd1(), rnd6(), rnd6(), full(mk(S_DECODE, F_SE, 2'b10, 2'b00, A_ADD, 2'b00)));
        if (!is_legal(op)) begin
            fault_seq(2'b10, hold);
            return;
        end
        if (op == OP_BEQ) begin
            step(1'b1, rnd1(), rnd6(), rnd6(), full(mk(S_BRJ, F_PCWC, 2'b00, 2'b01, A_SUB, 2'b00)));
            return;
        end
        if (op == OP_J) begin
            step(1'b1, rnd1(), rnd6(), rnd6(), full(mk(S_BRJ, F_PCW, 2'b00, 2'b10, A_AND, 2'b00)));
            return;
        end

        // EXEC
        if (is_r) begin
            step(1'b1, rnd1(), rnd6(), rnd6(),
                 full(mk(S_EXEC, shift ? F_S1 : 11'h0, shift ? 2'b11 : 2'b00, 2'b00, A_FUNC, 2'b00)));
        end else if (is_lw || is_sw) begin
            step(1'b1, rnd1(), rnd6(), rnd6(), full(mk(S_EXEC, F_SE, 2'b10, 2'b00, A_ADD, 2'b00)));
        end else begin
            row = imm_row(op);
            step(1'b1, rnd1(), rnd6(), rnd6(),
                 full(mk(S_EXEC, row[4] ? F_SE : 11'h0, 2'b10, 2'b00, row[3:0], 2'b00)));
        end

        // MEM
        if (is_lw || is_sw) begin
            for (int i = 0; i <= t; i++) begin
                r  = (i >= mwait);
                fl = F_IORD | (is_lw ? F_MR : F_MW);
                if (i == abort_at) begin
                    step(1'b0, r, rnd6(), rnd6(),
                         full(mk(S_MEM, fl & ~STROBE_FL, 2'b00, 2'b00, A_AND, 2'b00)));
                    return;
                end
                step(1'b1, r, rnd6(), rnd6(), full(mk(S_MEM, fl, 2'b00, 2'b00, A_AND, 2'b00)));
                if (r) break;
                if (i + 1 == t) begin
                    fault_seq(2'b01, hold);
                    return;
                end
            end
            if (is_sw) return;
        end

        // WB
        fl = F_RW | (is_r ? F_RD : 11'h0) | (is_lw ? F_M2R : 11'h0);
        step(1'b1, rnd1(), rnd6(), rnd6(), full(mk(S_WB, fl, 2'b00, 2'b00, A_AND, 2'b00)));
    endtask

    task automatic random_run(input int n);
        int t;
        t = (cur == 0) ? TO_A : TO_B;
        for (int k = 0; k < n; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         fw, mwv, ab;
            if ($urandom_range(0, 9) == 0) begin
                do op = rnd6(); while (is_legal(op));
            end else begin
                op = LEGAL[$urandom_range(0, 12)];
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : rnd6();
            fw  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, t + 1) : $urandom_range(0, 2);
            mwv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, t + 1) : $urandom_range(0, 2);
            ab  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
            run_instr(op, fn, fw, mwv, ab, $urandom_range(1, 5));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        total = 0; bad = 0; cur = 0; zero_mode = -1;
        rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        zero_a = 1'b0; zero_b = 1'b0;
        op_a = 6'd0; op_b = 6'd0; fn_a = 6'd0; fn_b = 6'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with MemReady=1: strobes must stay low
        step(1'b0, 1'b1, rnd6(), rnd6(), {STROBE_MASK, 25'd0});

        // ADD after one ready-low FETCH cycle (first cycle pins reset state)
        obs_q.delete();
        run_instr(OP_R, 6'b100000, 1, 0, -1, 0);
        chk("reset_state", 32'(obs_q[0]), 32'h0010108);
        chk("add_len", obs_q.size(), 5);
        chk("add_states", {obs_q[1][24:21], obs_q[2][24:21], obs_q[3][24:21], obs_q[4][24:21]}, 16'h0124);
        chk("add_exec_aluop", 32'(obs_q[3][5:2]), 32'hF);
        chk("add_exec_regwrite", 32'(obs_q[3][12]), 32'h0);
        chk("add_wb_regdst_regwrite", 32'(obs_q[4][13:12]), 32'h3);

        // LW with three ready-low MEM cycles
        obs_q.delete();
        run_instr(OP_LW, rnd6(), 0, 3, -1, 0);
        n = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][24:21] == 4'd3) n++;
        chk("lw_len", obs_q.size(), 8);
        chk("lw_mem_cycles", n, 4);
        chk("lw_wb_state", 32'(obs_q[7][24:21]), 32'h4);
        chk("lw_wb_memtoreg", 32'(obs_q[7][14]), 32'h1);

        // BEQ with Zero=1
        zero_mode = 1;
        obs_q.delete();
        run_instr(OP_BEQ, rnd6(), 0, 0, -1, 0);
        zero_mode = -1;
        chk("beq_states", {obs_q[0][24:21], obs_q[1][24:21], obs_q[2][24:21]}, 12'h015);
        chk("beq_pcwritecond", 32'(obs_q[2][19]), 32'h1);
        chk("beq_pcsource", 32'(obs_q[2][7:6]), 32'h1);
        chk("beq_aluop", 32'(obs_q[2][5:2]), 32'h6);

        // Undefined opcode: FAULT held 10 cycles, then one reset cycle
        obs_q.delete();
        run_instr(6'b111111, 6'd0, 0, 0, -1, 10);
        n = 0;
        for (int i = 2; i < 12; i++) if (obs_q[i][24:21] == 4'hF && obs_q[i][1]) n++;
        chk("illegal_decode", 32'(obs_q[1][24:21]), 32'h1);
        chk("illegal_held", n, 10);
        obs_q.delete();
        run_instr(OP_J, rnd6(), 0, 0, -1, 0);
        chk("post_reset_state", 32'(obs_q[0][24:21]), 32'h0);
        chk("post_reset_illegal", 32'(obs_q[0][1]), 32'h0);
        chk("j_pcwrite", 32'(obs_q[2][20]), 32'h1);
        chk("j_pcsource", 32'(obs_q[2][7:6]), 32'h2);

        // SW interrupted by reset during its MEM wait
        obs_q.delete();
        run_instr(OP_SW, rnd6(), 0, 5, 2, 0);
        chk("sw_abort_memwrite", 32'(obs_q[5][15]), 32'h0);
        obs_q.delete();
        run_instr(OP_R, 6'b100010, 0, 0, -1, 0);
        chk("sw_abort_next_state", 32'(obs_q[0][24:21]), 32'h0);
        chk("sw_abort_next_memwrite", 32'(obs_q[0][15]), 32'h0);

        random_run(150);

        // Switch to the MEM_TIMEOUT=3 instance
        rst_a = 1'b0;
        cur = 1;
        obs_q.delete();
        run_instr(OP_R, 6'b100000, 5, 0, -1, 3);
        chk("to_fetch_wait_state", 32'(obs_q[2][24:21]), 32'h0);
        chk("to_fault_state", 32'(obs_q[3][24:21]), 32'hF);
        chk("to_fault_timeout", 32'(obs_q[3][1:0]), 32'h1);
        obs_q.delete();
        run_instr(OP_R, 6'b100000, 2, 0, -1, 3);
        chk("ready_wins_irwrite", 32'(obs_q[2][18]), 32'h1);
        chk("ready_wins_decode", 32'(obs_q[3][24:21]), 32'h1);

        random_run(100);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: MultiCycleControl

Interface
REQ-001 Parameter ALUOP_W, default 4, sets ALUOp width; SHALL be >= 4, with codes zero-extended from the 4-bit ALU encoding (AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, XOR 1010, SLTU 1011, SRA 1101, LUI 1110, FUNC 1111).
REQ-002 Parameter MEM_TIMEOUT, default 15, is the maximum number of memory wait cycles before a fault; range 1..255.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset_L  input  1  synchronous, active-low reset.
REQ-005 Opcode  input  6  instruction[31:26]; FuncCode  input  6  instruction[5:0]; Zero  input  1  ALU zero flag.
REQ-006 MemReady  input  1  memory completes the current read/write this cycle.
REQ-007 PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrc1, SignExtend  output  1 each  datapath controls.
REQ-008 ALUSrc2  output  2  00 rt, 01 const 4, 10 extended immediate, 11 shamt; PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 ALUOp  output  ALUOP_W  ALU operation; IllegalOp  output  1  undefined opcode fault; Timeout  output  1  memory timeout fault; State  output  4  current state, for debug.

Function
REQ-010 States: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRJ 5, FAULT 15; all other codes SHALL be unreachable.
REQ-011 Outputs SHALL be Moore, decoded from state plus latched opcode/func; unlisted controls are 0.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrc1=0, ALUSrc2=01, ALUOp=ADD; when MemReady=1 assert IRWrite=1 and PCWrite=1 (PCSource=00) and go to DECODE; else hold.
REQ-013 The opcode and FuncCode SHALL be latched on the FETCH cycle with IRWrite=1 and used for all later states of that instruction.
REQ-014 DECODE: ALUSrc1=0, ALUSrc2=10, SignExtend=1, ALUOp=ADD (branch target to ALUOut); go to BRJ for BEQ/J, EXEC for R-type, LW, SW and I-type ALU ops, FAULT for any other opcode.
REQ-015 EXEC: R-type gives ALUOp=FUNC with ALUSrc2=11 and ALUSrc1=1 for SLL/SRL/SRA, else ALUSrc2=00; LW/SW give ADD, ALUSrc2=10, SignExtend=1; ORI/ANDI/XORI/ADDIU/SLTIU/ADDI/SLTI/LUI give OR/AND/XOR/ADDU/SLTU/ADD/SLT/LUI with ALUSrc2=10 and SignExtend=1 only for ADDI/SLTI; next state MEM for LW/SW, WB otherwise.
REQ-016 MEM: IorD=1, MemRead=1 for LW, MemWrite=1 for SW; on MemReady=1 go to WB for LW, FETCH for SW; else hold.
REQ-017 WB: RegWrite=1; RegDst=1 only for R-type; MemToReg=1 only for LW; next FETCH.
REQ-018 BRJ: BEQ gives ALUOp=SUB, ALUSrc2=00, PCWriteCond=1, PCSource=01; J gives PCWrite=1, PCSource=10; next FETCH.
REQ-019 Latency SHALL be (MemReady always 1): R-type/I-type 4 cycles, LW 5, SW 4, BEQ 3, J 3.
REQ-020 An 8-bit wait counter SHALL clear on entry to FETCH or MEM, increment each cycle held there with MemReady=0, and on reaching MEM_TIMEOUT with MemReady=0 go to FAULT with Timeout=1.
REQ-021 MemReady=1 on the cycle the counter reaches MEM_TIMEOUT SHALL complete normally (ready wins).
REQ-022 FAULT: all datapath controls 0, IllegalOp or Timeout held at 1; exit only by reset.
REQ-023 MemReady outside FETCH/MEM SHALL be ignored.

Reset
REQ-024 Reset_L=0 sampled on a rising edge SHALL, regardless of state (including mid-MEM wait or FAULT), set State=FETCH, wait counter=0, latched opcode/func=0, IllegalOp=0, Timeout=0.
REQ-025 During and immediately after reset all write strobes (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) SHALL be 0 until a FETCH with MemReady=1.

Verification
REQ-026 ADD (op 000000, func 100000), MemReady=1 -> states 0,1,2,4; ALUOp=1111 in EXEC; RegWrite=1, RegDst=1 in WB only.
REQ-027 LW (100011), MemReady low 3 cycles in MEM -> MEM held 4 cycles, then WB with MemToReg=1; total 8 cycles.
REQ-028 BEQ (000100), Zero=1 -> BRJ with PCWriteCond=1, PCSource=01, ALUOp=0110; back to FETCH after 3 cycles.
REQ-029 Opcode 111111 -> DECODE then FAULT, IllegalOp=1 held 10 cycles; Reset_L=0 one cycle -> FETCH, IllegalOp=0.
REQ-030 MEM_TIMEOUT=3, MemReady=0 in FETCH -> FAULT with Timeout=1 after 3 wait cycles; repeat with MemReady=1 on the 3rd -> DECODE.
REQ-031 Reset_L=0 asserted during SW MEM wait -> next cycle FETCH, MemWrite=0.
